// File: rtl/i_enc_input_filter.sv
// Quadrature pin conditioner: per-pin synchroniser, glitch filter, edge strobes and A/B illegal-transition flag.
// Define ENC_FILT_DBG_EN to build the saturating rejected-glitch counters on O_DBG_GLITCH_A/B/Z.
module i_enc_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8
) (
  input  logic        I_CLK_100MHZ,
  input  logic        I_RST,
  input  logic        I_ENC_A,
  input  logic        I_ENC_B,
  input  logic        I_ENC_Z,
  input  logic        I_CLR_ERR,
  output logic        O_VALID,
  output logic        O_ENC_A,
  output logic        O_ENC_B,
  output logic        O_ENC_Z,
  output logic        O_POSEDGE_A,
  output logic        O_POSEDGE_B,
  output logic        O_POSEDGE_Z,
  output logic        O_NEGEDGE_A,
  output logic        O_NEGEDGE_B,
  output logic        O_NEGEDGE_Z,
  output logic        O_ILLEGAL,
  output logic        O_ERR_STICKY,
  output logic [15:0] O_DBG_GLITCH_A,
  output logic [15:0] O_DBG_GLITCH_B,
  output logic [15:0] O_DBG_GLITCH_Z
);

  typedef enum logic [1:0] {RST_WAIT, FILL, LOAD, RUN} state_t;

  localparam logic [7:0] FILT_LAST = 8'(FILT_LEN - 1);
  localparam logic [1:0] FILL_LAST = 2'(SYNC_STAGES - 1);

  state_t     state, state_nxt;
  logic [1:0] fill_cnt;

  // Pin index 0 = A, 1 = B, 2 = Z throughout.
  logic [2:0] raw;
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] sync_out;
  logic [7:0] filt_cnt [3];
  logic [2:0] enc_q, pos_q, neg_q;
  logic [2:0] accept;
  logic       illegal_q, err_q;

  assign raw      = {I_ENC_Z, I_ENC_B, I_ENC_A};
  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) state <= RST_WAIT;
    else       state <= state_nxt;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      RST_WAIT: state_nxt = FILL;
      FILL:     if (fill_cnt == FILL_LAST) state_nxt = LOAD;
      LOAD:     state_nxt = RUN;
      RUN:      state_nxt = RUN;
      default:  state_nxt = RST_WAIT;
    endcase
  end

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST || state != FILL) fill_cnt <= '0;
    else                        fill_cnt <= fill_cnt + 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < 3; i++)
      accept[i] = (state == RUN) && (sync_out[i] != enc_q[i]) && (filt_cnt[i] == FILT_LAST);
  end

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      enc_q     <= '0;
      pos_q     <= '0;
      neg_q     <= '0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 3; i++) filt_cnt[i] <= '0;
    end else begin
      pos_q     <= '0;
      neg_q     <= '0;
      illegal_q <= accept[0] & accept[1];
      // A registered illegal in the same cycle as a clear keeps the flag set.
      err_q     <= illegal_q | (err_q & ~I_CLR_ERR);
      for (int i = 0; i < 3; i++) begin
        if (state == LOAD) begin
          enc_q[i]    <= sync_out[i];
          filt_cnt[i] <= '0;
        end else if (state == RUN) begin
          if (sync_out[i] == enc_q[i]) begin
            filt_cnt[i] <= '0;
          end else if (accept[i]) begin
            enc_q[i]    <= sync_out[i];
            filt_cnt[i] <= '0;
            pos_q[i]    <= sync_out[i];
            neg_q[i]    <= ~sync_out[i];
          end else begin
            filt_cnt[i] <= filt_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

`ifdef ENC_FILT_DBG_EN
  logic [15:0] glitch_cnt [3];
  logic [2:0]  glitch;

  // A glitch is a partially-counted excursion that collapses back to the held level.
  always_comb begin
    glitch = '0;
    for (int i = 0; i < 3; i++)
      glitch[i] = (state == RUN) && (filt_cnt[i] != 8'd0) && (sync_out[i] == enc_q[i]);
  end

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      for (int i = 0; i < 3; i++) glitch_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (glitch[i] && glitch_cnt[i] != 16'hFFFF) glitch_cnt[i] <= glitch_cnt[i] + 16'd1;
    end
  end

  assign O_DBG_GLITCH_A = glitch_cnt[0];
  assign O_DBG_GLITCH_B = glitch_cnt[1];
  assign O_DBG_GLITCH_Z = glitch_cnt[2];
`else
  assign O_DBG_GLITCH_A = 16'd0;
  assign O_DBG_GLITCH_B = 16'd0;
  assign O_DBG_GLITCH_Z = 16'd0;
`endif

  assign O_VALID      = (state == RUN);
  assign O_ENC_A      = enc_q[0];
  assign O_ENC_B      = enc_q[1];
  assign O_ENC_Z      = enc_q[2];
  assign O_POSEDGE_A  = pos_q[0];
  assign O_POSEDGE_B  = pos_q[1];
  assign O_POSEDGE_Z  = pos_q[2];
  assign O_NEGEDGE_A  = neg_q[0];
  assign O_NEGEDGE_B  = neg_q[1];
  assign O_NEGEDGE_Z  = neg_q[2];
  assign O_ILLEGAL    = illegal_q;
  assign O_ERR_STICKY = err_q;

endmodule

// File: tb/tb_i_enc_input_filter.sv
// Directed bench for i_enc_input_filter (SYNC_STAGES=2, FILT_LEN=8); cycle counts include the sampling edge.
module tb_i_enc_input_filter;

  logic        clk = 1'b0;
  logic        rst, enc_a, enc_b, enc_z, clr_err;
  logic        valid, o_a, o_b, o_z;
  logic        pos_a, pos_b, pos_z, neg_a, neg_b, neg_z;
  logic        illegal, err_sticky;
  logic [15:0] dbg_a, dbg_b, dbg_z;

`ifdef ENC_FILT_DBG_EN
  localparam logic [15:0] DBG_ONE = 16'd1;
`else
  localparam logic [15:0] DBG_ONE = 16'd0;
`endif

  int checks = 0;
  int errors = 0;
  int n_pos[3];
  int n_neg[3];
  int n_ill;
  int ev_q[$];
  int strobe_sum;

  always #5 clk = ~clk;

  i_enc_input_filter #(.SYNC_STAGES(2), .FILT_LEN(8)) dut (
    .I_CLK_100MHZ  (clk),
    .I_RST         (rst),
    .I_ENC_A       (enc_a),
    .I_ENC_B       (enc_b),
    .I_ENC_Z       (enc_z),
    .I_CLR_ERR     (clr_err),
    .O_VALID       (valid),
    .O_ENC_A       (o_a),
    .O_ENC_B       (o_b),
    .O_ENC_Z       (o_z),
    .O_POSEDGE_A   (pos_a),
    .O_POSEDGE_B   (pos_b),
    .O_POSEDGE_Z   (pos_z),
    .O_NEGEDGE_A   (neg_a),
    .O_NEGEDGE_B   (neg_b),
    .O_NEGEDGE_Z   (neg_z),
    .O_ILLEGAL     (illegal),
    .O_ERR_STICKY  (err_sticky),
    .O_DBG_GLITCH_A(dbg_a),
    .O_DBG_GLITCH_B(dbg_b),
    .O_DBG_GLITCH_Z(dbg_z)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) begin
      n_pos[i] = 0;
      n_neg[i] = 0;
    end
    n_ill = 0;
    ev_q.delete();
  endtask

  // Step n cycles, logging every strobe (codes: 1 posA, 2 posB, 3 negA, 4 negB).
  task automatic tick_mon(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (pos_a) begin n_pos[0]++; ev_q.push_back(1); end
      if (pos_b) begin n_pos[1]++; ev_q.push_back(2); end
      if (neg_a) begin n_neg[0]++; ev_q.push_back(3); end
      if (neg_b) begin n_neg[1]++; ev_q.push_back(4); end
      if (pos_z) n_pos[2]++;
      if (neg_z) n_neg[2]++;
      if (illegal) n_ill++;
    end
  endtask

  initial begin
    rst = 1'b1; enc_a = 1'b1; enc_b = 1'b0; enc_z = 1'b0; clr_err = 1'b0;
    clear_mon();

    // 1. Reset with A=1 held, then init sequence.
    tick(); tick(); tick();
    check("rst_valid", valid, 0);
    check("rst_enc_a", o_a, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_dbg_a", dbg_a, 0);
    rst = 1'b0;
    tick_mon(3);
    check("init_valid_early", valid, 0);
    tick_mon(1);
    check("init_valid", valid, 1);
    check("init_enc_a", o_a, 1);
    check("init_enc_b", o_b, 0);
    strobe_sum = n_pos[0] + n_pos[1] + n_pos[2] + n_neg[0] + n_neg[1] + n_neg[2];
    check("init_no_strobe", 16'(strobe_sum), 0);

    // 2. A fall, then A rise: 10-cycle latency, 1-cycle strobe.
    enc_a = 1'b0;
    tick_mon(10);
    check("a_fall_enc", o_a, 0);
    check("a_fall_neg", neg_a, 1);
    tick();
    enc_a = 1'b1;
    tick_mon(9);
    check("a_rise_enc_early", o_a, 0);
    check("a_rise_pos_early", pos_a, 0);
    tick_mon(1);
    check("a_rise_enc", o_a, 1);
    check("a_rise_pos", pos_a, 1);
    tick();
    check("a_rise_pos_width", pos_a, 0);
    check("a_rise_enc_hold", o_a, 1);

    // 3. 7-cycle glitch on B is rejected; 8-cycle pulse is passed.
    clear_mon();
    enc_b = 1'b1;
    tick_mon(7);
    enc_b = 1'b0;
    tick_mon(12);
    check("b_glitch_enc", o_b, 0);
    check("b_glitch_pos", 16'(n_pos[1]), 0);
    check("b_glitch_dbg", dbg_b, DBG_ONE);
    check("a_dbg_untouched", dbg_a, 0);
    clear_mon();
    enc_b = 1'b1;
    tick_mon(8);
    enc_b = 1'b0;
    tick_mon(22);
    check("b_pulse8_pos", 16'(n_pos[1]), 1);
    check("b_pulse8_neg", 16'(n_neg[1]), 1);
    check("b_pulse8_dbg", dbg_b, DBG_ONE);
    check("b_pulse8_illegal", 16'(n_ill), 0);

    // 4. Simultaneous A/B change -> illegal; clear; illegal+clear keeps it set.
    enc_a = 1'b0;
    tick_mon(12);
    enc_a = 1'b1; enc_b = 1'b1;
    tick_mon(10);
    check("ill_strobe", illegal, 1);
    check("ill_pos_a", pos_a, 1);
    check("ill_pos_b", pos_b, 1);
    check("ill_enc_b", o_b, 1);
    tick();
    check("ill_width", illegal, 0);
    check("ill_sticky", err_sticky, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_sticky", err_sticky, 0);
    enc_a = 1'b0; enc_b = 1'b0;
    tick_mon(10);
    check("ill2_strobe", illegal, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ill_clr_set_wins", err_sticky, 1);

    // 5. Reset while A filter count is 5.
    enc_a = 1'b1;
    tick_mon(7);
    check("midfilt_enc_a", o_a, 0);
    rst = 1'b1;
    tick();
    check("midrst_valid", valid, 0);
    check("midrst_sticky", err_sticky, 0);
    check("midrst_pos_a", pos_a, 0);
    check("midrst_dbg_b", dbg_b, 0);
    rst = 1'b0;
    clear_mon();
    tick_mon(3);
    check("rerun_valid_early", valid, 0);
    tick_mon(1);
    check("rerun_valid", valid, 1);
    check("rerun_enc_a", o_a, 1);
    tick_mon(12);
    strobe_sum = n_pos[0] + n_pos[1] + n_pos[2] + n_neg[0] + n_neg[1] + n_neg[2];
    check("rerun_no_stale", 16'(strobe_sum), 0);

    // 6. CW quadrature cycle, 20-cycle phases, Z rides with A.
    enc_a = 1'b0;
    tick_mon(12);
    clear_mon();
    enc_a = 1'b1; enc_z = 1'b1;
    tick_mon(20);
    enc_b = 1'b1;
    tick_mon(20);
    enc_a = 1'b0; enc_z = 1'b0;
    tick_mon(20);
    enc_b = 1'b0;
    tick_mon(20);
    check("cw_count", 16'(ev_q.size()), 4);
    if (ev_q.size() == 4) begin
      check("cw_ev0_posA", 16'(ev_q[0]), 1);
      check("cw_ev1_posB", 16'(ev_q[1]), 2);
      check("cw_ev2_negA", 16'(ev_q[2]), 3);
      check("cw_ev3_negB", 16'(ev_q[3]), 4);
    end
    check("cw_no_illegal", 16'(n_ill), 0);
    check("cw_z_pos", 16'(n_pos[2]), 1);
    check("cw_z_neg", 16'(n_neg[2]), 1);
    check("cw_sticky", err_sticky, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
